// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute stage behind the ALU control decoder.
// ADD, SUB and LUI finish one cycle after acceptance. MUL is an iterative shift-add
// that takes DATA_WIDTH iterations.
// Optional macro ALU_SEQ_DIV_EN adds DIVU (0100) and REMU (0101) as a restoring
// divider. The divider reuses the RUN state and the iteration counter. Without the
// macro these codes are unsupported.
// Ports:
//   clk, reset       rising-edge clock; synchronous active-high reset
//   start_i          request valid, accepted only while ready_o=1
//   ALU_Operation_i  4-bit operation code
//   A_i, B_i         operands, latched at the accept edge
//   ready_o          high in IDLE
//   busy_o           high in RUN
//   done_o           one-cycle completion pulse
//   ALU_Result_o     registered result, held until the next completion
//   Zero_o           high when ALU_Result_o == 0
//   illegal_op_o     pulses with done_o for unsupported codes
module alu_seq_exec #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  ready_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  illegal_op_o
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_LUI  = 4'b0010;
  localparam logic [3:0] OP_MUL  = 4'b0011;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b0100;
  localparam logic [3:0] OP_REMU = 4'b0101;
`endif
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

  state_t                state, state_d;
  logic [CNT_WIDTH-1:0]  cnt, cnt_d;
  // op_a: multiplicand, or dividend that shifts into the quotient.
  // op_b: multiplier, or divisor.
  // acc:  product accumulator, or partial remainder.
  logic [DATA_WIDTH-1:0] op_a, op_a_d;
  logic [DATA_WIDTH-1:0] op_b, op_b_d;
  logic [DATA_WIDTH-1:0] acc, acc_d;
  logic                  ill_pend, ill_pend_d;
  logic [DATA_WIDTH-1:0] res_d;
  logic                  ready_d, busy_d, done_d, zero_d, illegal_d;
  logic [DATA_WIDTH-1:0] mul_sum;

  // One shift-add step: add the multiplicand when the multiplier LSB is set.
  assign mul_sum = acc + (op_b[0] ? op_a : '0);

`ifdef ALU_SEQ_DIV_EN
  logic [3:0]            op_q, op_q_d;
  logic [DATA_WIDTH:0]   div_shift, div_diff;
  logic                  div_ge;

  // One restoring-division step. Bring the next dividend bit into the remainder and
  // try to subtract the divisor. A zero divisor always "fits", so the quotient
  // becomes all ones and the remainder ends up equal to A.
  assign div_shift = {acc, op_a[DATA_WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, op_b};
  assign div_ge    = ~div_diff[DATA_WIDTH];
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      ill_pend     <= 1'b0;
      ALU_Result_o <= '0;
      Zero_o       <= 1'b1;
      ready_o      <= 1'b1;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      illegal_op_o <= 1'b0;
`ifdef ALU_SEQ_DIV_EN
      op_q         <= '0;
`endif
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      op_a         <= op_a_d;
      op_b         <= op_b_d;
      acc          <= acc_d;
      ill_pend     <= ill_pend_d;
      ALU_Result_o <= res_d;
      Zero_o       <= zero_d;
      ready_o      <= ready_d;
      busy_o       <= busy_d;
      done_o       <= done_d;
      illegal_op_o <= illegal_d;
`ifdef ALU_SEQ_DIV_EN
      op_q         <= op_q_d;
`endif
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    op_a_d     = op_a;
    op_b_d     = op_b;
    acc_d      = acc;
    ill_pend_d = ill_pend;
    res_d      = ALU_Result_o;
`ifdef ALU_SEQ_DIV_EN
    op_q_d     = op_q;
`endif

    unique case (state)
      ST_IDLE: begin
        if (start_i) begin
          ill_pend_d = 1'b0;
`ifdef ALU_SEQ_DIV_EN
          op_q_d     = ALU_Operation_i;
`endif
          state_d    = ST_DONE;
          case (ALU_Operation_i)
            OP_ADD: res_d = A_i + B_i;
            OP_SUB: res_d = A_i - B_i;
            OP_LUI: res_d = B_i;
`ifdef ALU_SEQ_DIV_EN
            OP_MUL, OP_DIVU, OP_REMU: begin
`else
            OP_MUL: begin
`endif
              op_a_d  = A_i;
              op_b_d  = B_i;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = ST_RUN;
            end
            default: begin
              res_d      = '0;
              ill_pend_d = 1'b1;
            end
          endcase
        end
      end

      ST_RUN: begin
        cnt_d = cnt + CNT_WIDTH'(1);
`ifdef ALU_SEQ_DIV_EN
        if (op_q == OP_MUL) begin
          acc_d  = mul_sum;
          op_a_d = op_a << 1;
          op_b_d = op_b >> 1;
        end else begin
          acc_d  = div_ge ? div_diff[DATA_WIDTH-1:0] : div_shift[DATA_WIDTH-1:0];
          op_a_d = {op_a[DATA_WIDTH-2:0], div_ge};
        end
        if (cnt == LAST_CNT) begin
          state_d = ST_DONE;
          res_d   = (op_q == OP_DIVU) ? op_a_d : acc_d;
        end
`else
        acc_d  = mul_sum;
        op_a_d = op_a << 1;
        op_b_d = op_b >> 1;
        if (cnt == LAST_CNT) begin
          state_d = ST_DONE;
          res_d   = acc_d;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase

    // The flags are registered from the next state, so they line up with the state register.
    ready_d   = (state_d == ST_IDLE);
    busy_d    = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    illegal_d = (state_d == ST_DONE) && ill_pend_d;
    zero_d    = (res_d == '0);
  end

endmodule

// File: tb/tb_alu_seq_exec.sv
// Self-checking bench for alu_seq_exec.
// A table of vectors is pushed through a scoreboard queue. Hand-written sequences
// cover reset, a start pulse during RUN, and a reset that aborts a multiply.
module tb_alu_seq_exec;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [3:0]    op;
  logic [DW-1:0] a, b;
  logic          ready_o, busy_o, done_o, Zero_o, illegal_op_o;
  logic [DW-1:0] ALU_Result_o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [3:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] res;
    bit            ill;
    int            lat;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  alu_seq_exec #(.DATA_WIDTH(DW), .CNT_WIDTH(6)) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(op),
    .A_i            (a),
    .B_i            (b),
    .ready_o        (ready_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ALU_Result_o   (ALU_Result_o),
    .Zero_o         (Zero_o),
    .illegal_op_o   (illegal_op_o)
  );

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      n_pass++;
  endtask

  // Wait for done_o. Count the cycles since acceptance and the cycles with busy_o high.
  task automatic wait_done(output int lat, output int busy_n);
    lat = 1;
    busy_n = 0;
    while (!done_o && lat < 200) begin
      if (busy_o) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic do_op(input vec_t v);
    int   lat, busy_n;
    vec_t e;
    @(negedge clk);
    start_i = 1'b1; op = v.op; a = v.a; b = v.b;
    sb.push_back(v);
    @(negedge clk);
    start_i = 1'b0; a = $urandom; b = $urandom;
    wait_done(lat, busy_n);
    e = sb.pop_front();
    check($sformatf("done_seen op%h", e.op), 32'(done_o), 32'd1);
    check($sformatf("latency op%h", e.op), 32'(lat), 32'(e.lat));
    check($sformatf("busy_cycles op%h", e.op), 32'(busy_n), (e.lat == 1) ? 32'd0 : 32'(DW));
    check($sformatf("result op%h a=%h b=%h", e.op, e.a, e.b), ALU_Result_o, e.res);
    check($sformatf("zero op%h", e.op), 32'(Zero_o), 32'(e.res == '0));
    check($sformatf("illegal op%h", e.op), 32'(illegal_op_o), 32'(e.ill));
    check($sformatf("ready_in_done op%h", e.op), 32'(ready_o), 32'd0);
    @(negedge clk);
    check($sformatf("done_pulse_end op%h", e.op), 32'(done_o), 32'd0);
    check($sformatf("illegal_pulse_end op%h", e.op), 32'(illegal_op_o), 32'd0);
    check($sformatf("ready_after op%h", e.op), 32'(ready_o), 32'd1);
    check($sformatf("result_held op%h", e.op), ALU_Result_o, e.res);
  endtask

  initial begin
    int   seen;
    int   lat, busy_n;
    vec_t e;

    vecs.push_back('{4'b0001, 32'h5, 32'h5, 32'h0, 1'b0, 1});
    vecs.push_back('{4'b0000, 32'hFFFF_FFFF, 32'h2, 32'h1, 1'b0, 1});
    vecs.push_back('{4'b0011, 32'h0001_0003, 32'h7, 32'h0007_0015, 1'b0, DW + 1});
    vecs.push_back('{4'b0010, 32'hDEAD_BEEF, 32'h1234_5000, 32'h1234_5000, 1'b0, 1});
    vecs.push_back('{4'b1111, 32'h1, 32'h2, 32'h0, 1'b1, 1});
    vecs.push_back('{4'b0001, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1});
    vecs.push_back('{4'b0011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 1'b0, DW + 1});
    vecs.push_back('{4'b0011, 32'h1234_5678, 32'h0, 32'h0, 1'b0, DW + 1});
    vecs.push_back('{4'b0011, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 1'b0, DW + 1});
    vecs.push_back('{4'b0110, 32'h3, 32'h3, 32'h0, 1'b1, 1});
`ifdef ALU_SEQ_DIV_EN
    vecs.push_back('{4'b0100, 32'd100, 32'd7, 32'd14, 1'b0, DW + 1});
    vecs.push_back('{4'b0101, 32'd100, 32'd7, 32'd2, 1'b0, DW + 1});
    vecs.push_back('{4'b0100, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, DW + 1});
    vecs.push_back('{4'b0101, 32'd9, 32'd0, 32'd9, 1'b0, DW + 1});
    vecs.push_back('{4'b0100, 32'hFFFF_FFFF, 32'h1_0000, 32'h0000_FFFF, 1'b0, DW + 1});
`else
    vecs.push_back('{4'b0100, 32'd100, 32'd7, 32'h0, 1'b1, 1});
    vecs.push_back('{4'b0101, 32'd100, 32'd7, 32'h0, 1'b1, 1});
`endif

    // Reset state
    reset = 1'b1; start_i = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_result", ALU_Result_o, 32'h0);
    check("rst_zero", 32'(Zero_o), 32'd1);
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_illegal", 32'(illegal_op_o), 32'd0);

    // Table-driven vectors
    foreach (vecs[i]) do_op(vecs[i]);

    // A start pulse during RUN is ignored and does not produce a second done_o
    @(negedge clk);
    start_i = 1'b1; op = 4'b0011; a = 32'h0001_0003; b = 32'h7;
    sb.push_back('{4'b0011, 32'h0001_0003, 32'h7, 32'h0007_0015, 1'b0, DW + 1});
    @(negedge clk);
    start_i = 1'b0;
    repeat (4) @(negedge clk);
    start_i = 1'b1; op = 4'b0000; a = 32'h1; b = 32'h1;
    @(negedge clk);
    start_i = 1'b0;
    wait_done(lat, busy_n);
    e = sb.pop_front();
    check("run_start_done_seen", 32'(done_o), 32'd1);
    check("run_start_result", ALU_Result_o, e.res);
    check("run_start_latency", 32'(lat + 5), 32'(e.lat));
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    check("run_start_no_second_done", 32'(seen), 32'd0);
    check("run_start_result_held", ALU_Result_o, 32'h0007_0015);

    // A reset during RUN aborts the multiply with no done_o
    @(negedge clk);
    start_i = 1'b1; op = 4'b0011; a = 32'h0001_0003; b = 32'h7;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    check("abort_busy_before", 32'(busy_o), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_busy", 32'(busy_o), 32'd0);
    check("abort_done", 32'(done_o), 32'd0);
    check("abort_result", ALU_Result_o, 32'h0);
    check("abort_zero", 32'(Zero_o), 32'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_op('{4'b0000, 32'd3, 32'd4, 32'd7, 1'b0, 1});

    // Reset has priority over a start on the same edge
    @(negedge clk);
    reset = 1'b1; start_i = 1'b1; op = 4'b0000; a = 32'd1; b = 32'd1;
    @(negedge clk);
    reset = 1'b0; start_i = 1'b0;
    check("rst_prio_done", 32'(done_o), 32'd0);
    check("rst_prio_result", ALU_Result_o, 32'h0);
    check("rst_prio_ready", 32'(ready_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
